// File: rtl/nch_trigger_sequencer_pkg.sv
// Shared definitions for the N-channel trigger sequencer: sequencer state
// encoding, default parameter values and a saturating-increment helper.
package trigger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_FIRE,
        ST_HOLDOFF
    } state_t;

    localparam int unsigned DEF_N_CH  = 4;
    localparam int unsigned DEF_WIN_W = 8;
    localparam int unsigned DEF_DLY_W = 12;
    localparam int unsigned DEF_HO_W  = 16;
    localparam int unsigned DEF_CNT_W = 32;
    localparam int unsigned DEF_TS_W  = 48;

    // Increment a counter of the given width (1..64), sticking at all-ones.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
        logic [63:0] max_val;
        max_val = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - width);
        return (val >= max_val) ? max_val : val + 64'd1;
    endfunction

endpackage

// File: rtl/nch_trigger_sequencer_coinc_window.sv
// Per-channel rising-edge detector with a reloadable coincidence window.
// The channel reports "open" on the edge cycle and while the window runs.
module coinc_window #(
    parameter int unsigned WIN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_signal,
    input  logic             i_mask,
    input  logic             i_arm,
    input  logic             i_clear,
    input  logic [WIN_W-1:0] i_load,
    output logic             o_open
);

    logic             r_prev;
    logic [WIN_W-1:0] r_win;
    logic             w_edge;

    assign w_edge = i_signal & ~r_prev & i_mask & i_arm;
    assign o_open = w_edge | (r_win != '0);

    // Previous-sample tracking always runs; window reloads on edge, else counts down.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
            r_win  <= '0;
        end else begin
            r_prev <= i_signal;
            if (i_clear) begin
                r_win <= '0;
            end else if (w_edge) begin
                r_win <= i_load;
            end else if (r_win != '0) begin
                r_win <= r_win - 1'b1;
            end
        end
    end

endmodule

// File: rtl/nch_trigger_sequencer.sv
// N-channel majority-coincidence trigger sequencer (IDLE/DELAY/FIRE/HOLDOFF)
// with saturating trigger, live-time and dead-time counters.
// Optional macro TRIG_TIMESTAMP_EN adds a free-running timestamp latched at FIRE.
module nch_trigger_sequencer
    import trigger_pkg::*;
#(
    parameter int unsigned N_CH  = DEF_N_CH,
    parameter int unsigned WIN_W = DEF_WIN_W,
    parameter int unsigned DLY_W = DEF_DLY_W,
    parameter int unsigned HO_W  = DEF_HO_W,
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned TS_W  = DEF_TS_W
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [N_CH-1:0]            SIGNAL,
    input  logic [N_CH-1:0]            CHANNEL_MASK,
    input  logic [$clog2(N_CH+1)-1:0]  MAJORITY,
    input  logic [WIN_W-1:0]           WINDOW,
    input  logic [DLY_W-1:0]           DELAY,
    input  logic [HO_W-1:0]            HOLDOFF,
    input  logic                       ENABLE,
    input  logic                       FORCE_TRIGGER,
    input  logic                       CLEAR_COUNTERS,
    output logic                       TRIGGER_OUT,
    output logic                       LIVE_ACQUISITION,
    output logic [N_CH-1:0]            TRIGGER_PATTERN,
    output logic [CNT_W-1:0]           NTRIGGERS,
    output logic [CNT_W-1:0]           LIVE_TIME,
    output logic [CNT_W-1:0]           DEAD_TIME,
    output logic [TS_W-1:0]            TIMESTAMP
);

    localparam int unsigned MAJ_W = $clog2(N_CH + 1);
    localparam int unsigned SEQ_W = (DLY_W > HO_W) ? DLY_W : HO_W;

    state_t             r_state;
    state_t             w_state_next;
    logic [SEQ_W-1:0]   r_seq_cnt;
    logic [SEQ_W-1:0]   w_seq_cnt_next;
    logic               r_force_prev;
    logic               w_force_edge;
    logic               w_idle;
    logic               w_accept;
    logic               w_coinc;
    logic               w_win_clear;
    logic [WIN_W-1:0]   w_win_load;
    logic [N_CH-1:0]    w_open;
    logic [MAJ_W-1:0]   w_open_cnt;
    logic [N_CH-1:0]    r_pattern;
    logic [CNT_W-1:0]   r_ntrig;
    logic [CNT_W-1:0]   r_live;
    logic [CNT_W-1:0]   r_dead;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_force_edge = FORCE_TRIGGER & ~r_force_prev;
    assign w_win_load   = (WINDOW == '0) ? '0 : WINDOW - 1'b1;
    // Windows are flushed on accept and held empty for the whole sequence.
    assign w_win_clear  = ~w_idle | w_accept;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        coinc_window #(.WIN_W(WIN_W)) u_win (
            .i_clk    (CLK),
            .i_rst_n  (RESET),
            .i_signal (SIGNAL[g]),
            .i_mask   (CHANNEL_MASK[g]),
            .i_arm    (w_idle),
            .i_clear  (w_win_clear),
            .i_load   (w_win_load),
            .o_open   (w_open[g])
        );
    end

    // Count open channels for the majority decision.
    always_comb begin
        w_open_cnt = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_open_cnt = w_open_cnt + MAJ_W'(w_open[i]);
        end
    end

    assign w_coinc = (MAJORITY != '0) && (w_open_cnt >= MAJORITY);

    // Sequencer next-state and delay/holdoff counter loading.
    always_comb begin
        w_state_next   = r_state;
        w_seq_cnt_next = r_seq_cnt;
        w_accept       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ENABLE && (w_coinc || w_force_edge)) begin
                    w_accept = 1'b1;
                    if (DELAY == '0) begin
                        w_state_next = ST_FIRE;
                    end else begin
                        w_state_next   = ST_DELAY;
                        w_seq_cnt_next = SEQ_W'(DELAY - 1'b1);
                    end
                end
            end
            ST_DELAY: begin
                if (r_seq_cnt == '0) begin
                    w_state_next = ST_FIRE;
                end else begin
                    w_seq_cnt_next = r_seq_cnt - 1'b1;
                end
            end
            ST_FIRE: begin
                if (HOLDOFF == '0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next   = ST_HOLDOFF;
                    w_seq_cnt_next = SEQ_W'(HOLDOFF - 1'b1);
                end
            end
            ST_HOLDOFF: begin
                if (r_seq_cnt == '0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_seq_cnt_next = r_seq_cnt - 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Sequencer state, counter and force-edge history registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state      <= ST_IDLE;
            r_seq_cnt    <= '0;
            r_force_prev <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_seq_cnt    <= w_seq_cnt_next;
            r_force_prev <= FORCE_TRIGGER;
        end
    end

    // Latch the open-channel pattern on accept; a pure software trigger records zero.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_pattern <= '0;
        end else if (w_accept) begin
            r_pattern <= w_coinc ? w_open : '0;
        end
    end

    // Saturating statistics counters; clear wins over increment.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_ntrig <= '0;
            r_live  <= '0;
            r_dead  <= '0;
        end else if (CLEAR_COUNTERS) begin
            r_ntrig <= '0;
            r_live  <= '0;
            r_dead  <= '0;
        end else begin
            if (r_state == ST_FIRE) r_ntrig <= CNT_W'(sat_inc(64'(r_ntrig), CNT_W));
            if (ENABLE && w_idle)   r_live  <= CNT_W'(sat_inc(64'(r_live), CNT_W));
            if (ENABLE && !w_idle)  r_dead  <= CNT_W'(sat_inc(64'(r_dead), CNT_W));
        end
    end

    assign TRIGGER_OUT      = (r_state == ST_FIRE);
    assign LIVE_ACQUISITION = ENABLE && w_idle;
    assign TRIGGER_PATTERN  = r_pattern;
    assign NTRIGGERS        = r_ntrig;
    assign LIVE_TIME        = r_live;
    assign DEAD_TIME        = r_dead;

`ifdef TRIG_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts_free;
    logic [TS_W-1:0] r_ts_latch;

    // Free-running time base, captured during the FIRE cycle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_ts_free  <= '0;
            r_ts_latch <= '0;
        end else begin
            r_ts_free <= r_ts_free + 1'b1;
            if (r_state == ST_FIRE) r_ts_latch <= r_ts_free;
        end
    end

    assign TIMESTAMP = r_ts_latch;
`else
    assign TIMESTAMP = '0;
`endif

endmodule

// File: tb/tb_nch_trigger_sequencer.sv
// Directed self-checking bench for nch_trigger_sequencer (N_CH=4, CNT_W=6 so
// that counter saturation is reachable). TIMESTAMP checks follow TRIG_TIMESTAMP_EN.
module tb_nch_trigger_sequencer;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned WIN_W = 8;
    localparam int unsigned DLY_W = 12;
    localparam int unsigned HO_W  = 16;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned TS_W  = 48;

    logic                      CLK = 1'b0;
    logic                      RESET;
    logic [N_CH-1:0]           SIGNAL;
    logic [N_CH-1:0]           CHANNEL_MASK;
    logic [2:0]                MAJORITY;
    logic [WIN_W-1:0]          WINDOW;
    logic [DLY_W-1:0]          DELAY;
    logic [HO_W-1:0]           HOLDOFF;
    logic                      ENABLE;
    logic                      FORCE_TRIGGER;
    logic                      CLEAR_COUNTERS;
    logic                      TRIGGER_OUT;
    logic                      LIVE_ACQUISITION;
    logic [N_CH-1:0]           TRIGGER_PATTERN;
    logic [CNT_W-1:0]          NTRIGGERS;
    logic [CNT_W-1:0]          LIVE_TIME;
    logic [CNT_W-1:0]          DEAD_TIME;
    logic [TS_W-1:0]           TIMESTAMP;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    longint unsigned ts_model = 0;

    nch_trigger_sequencer #(
        .N_CH  (N_CH),
        .WIN_W (WIN_W),
        .DLY_W (DLY_W),
        .HO_W  (HO_W),
        .CNT_W (CNT_W),
        .TS_W  (TS_W)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .SIGNAL           (SIGNAL),
        .CHANNEL_MASK     (CHANNEL_MASK),
        .MAJORITY         (MAJORITY),
        .WINDOW           (WINDOW),
        .DELAY            (DELAY),
        .HOLDOFF          (HOLDOFF),
        .ENABLE           (ENABLE),
        .FORCE_TRIGGER    (FORCE_TRIGGER),
        .CLEAR_COUNTERS   (CLEAR_COUNTERS),
        .TRIGGER_OUT      (TRIGGER_OUT),
        .LIVE_ACQUISITION (LIVE_ACQUISITION),
        .TRIGGER_PATTERN  (TRIGGER_PATTERN),
        .NTRIGGERS        (NTRIGGERS),
        .LIVE_TIME        (LIVE_TIME),
        .DEAD_TIME        (DEAD_TIME),
        .TIMESTAMP        (TIMESTAMP)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock; the timestamp model counts edges seen out of reset.
    task automatic tick();
        @(posedge CLK);
        if (RESET) ts_model++;
        #1;
    endtask

    task automatic settle();
        SIGNAL        = '0;
        FORCE_TRIGGER = 1'b0;
        repeat (8) tick();
    endtask

    // Step until armed again; reports cycles spent not live and fire strobes seen.
    task automatic wait_idle(output int unsigned dead, output int unsigned fires);
        dead  = 0;
        fires = 0;
        while (!LIVE_ACQUISITION && dead < 300) begin
            if (TRIGGER_OUT) fires++;
            dead++;
            tick();
        end
    endtask

    initial begin
        int unsigned dead;
        int unsigned fires;
        int unsigned notlive;
        longint unsigned exp_ts;

        RESET = 1'b0; SIGNAL = '0; CHANNEL_MASK = '0; MAJORITY = '0;
        WINDOW = '0; DELAY = '0; HOLDOFF = '0; ENABLE = 1'b0;
        FORCE_TRIGGER = 1'b0; CLEAR_COUNTERS = 1'b0;
        repeat (3) tick();

        check_eq("rst_trig",    64'(TRIGGER_OUT),      64'd0);
        check_eq("rst_live",    64'(LIVE_ACQUISITION), 64'd0);
        check_eq("rst_pattern", 64'(TRIGGER_PATTERN),  64'd0);
        check_eq("rst_ntrig",   64'(NTRIGGERS),        64'd0);
        check_eq("rst_livet",   64'(LIVE_TIME),        64'd0);
        check_eq("rst_deadt",   64'(DEAD_TIME),        64'd0);
        check_eq("rst_ts",      64'(TIMESTAMP),        64'd0);

        RESET = 1'b1;
        ts_model = 0;
        CHANNEL_MASK = 4'b1111; MAJORITY = 3'd2; WINDOW = 8'd5;
        DELAY = '0; HOLDOFF = 16'd10; ENABLE = 1'b1;
        tick();
        check_eq("armed_live", 64'(LIVE_ACQUISITION), 64'd1);

        // ch0 at cycle 0, ch2 at cycle 3: both inside the 5-cycle window.
        SIGNAL = 4'b0001;
        tick();
        check_eq("s1_no_early", 64'(TRIGGER_OUT), 64'd0);
        tick(); tick();
        check_eq("s1_no_early2", 64'(TRIGGER_OUT), 64'd0);
        SIGNAL = 4'b0101;
        tick();
        check_eq("s1_fire",    64'(TRIGGER_OUT),     64'd1);
        check_eq("s1_pattern", 64'(TRIGGER_PATTERN), 64'b0101);
        wait_idle(dead, fires);
        check_eq("s1_dead_cycles", 64'(dead),      64'd11);
        check_eq("s1_fire_count",  64'(fires),     64'd1);
        check_eq("s1_ntrig",       64'(NTRIGGERS), 64'd1);
        settle();

        // ch0 at cycle 0, ch1 at cycle 6: window expired, no coincidence.
        CLEAR_COUNTERS = 1'b1;
        tick();
        CLEAR_COUNTERS = 1'b0;
        check_eq("s2_cleared", 64'(NTRIGGERS), 64'd0);
        fires = 0;
        SIGNAL = 4'b0001;
        for (int c = 0; c < 14; c++) begin
            if (c == 6) SIGNAL = 4'b0011;
            tick();
            if (TRIGGER_OUT) fires++;
        end
        check_eq("s2_no_fire", 64'(fires),     64'd0);
        check_eq("s2_ntrig",   64'(NTRIGGERS), 64'd0);
        check_eq("s2_livet",   64'(LIVE_TIME), 64'd14);
        check_eq("s2_deadt",   64'(DEAD_TIME), 64'd0);
        settle();

        // Masked ch0 ignored; ch3 fires after DELAY=3 -> 4 cycles after its sample.
        CHANNEL_MASK = 4'b1110; MAJORITY = 3'd1; DELAY = 12'd3;
        SIGNAL = 4'b0001;
        fires = 0;
        repeat (3) begin
            tick();
            if (TRIGGER_OUT || !LIVE_ACQUISITION) fires++;
        end
        check_eq("s3_masked", 64'(fires), 64'd0);
        SIGNAL = 4'b1001;
        tick();
        for (int j = 1; j <= 4; j++) begin
            check_eq($sformatf("s3_lat%0d", j), 64'(TRIGGER_OUT), (j == 4) ? 64'd1 : 64'd0);
            if (j < 4) tick();
        end
        check_eq("s3_pattern", 64'(TRIGGER_PATTERN), 64'b1000);
        wait_idle(dead, fires);
        check_eq("s3_dead_cycles", 64'(dead), 64'd11);
        settle();

        // MAJORITY=0 disables coincidence; force fires once, second force in holdoff ignored.
        CHANNEL_MASK = 4'b1111; MAJORITY = 3'd0; DELAY = '0; HOLDOFF = 16'd20;
        SIGNAL = 4'b1111;
        fires = 0;
        repeat (3) begin
            tick();
            if (TRIGGER_OUT) fires++;
        end
        check_eq("s4_maj0_no_coinc", 64'(fires), 64'd0);
        settle();
        CLEAR_COUNTERS = 1'b1;
        tick();
        CLEAR_COUNTERS = 1'b0;
        FORCE_TRIGGER = 1'b1;
        tick();
        FORCE_TRIGGER = 1'b0;
        check_eq("s4_force_fire", 64'(TRIGGER_OUT),     64'd1);
        check_eq("s4_pattern",    64'(TRIGGER_PATTERN), 64'd0);
        repeat (4) tick();
        FORCE_TRIGGER = 1'b1;
        tick();
        FORCE_TRIGGER = 1'b0;
        wait_idle(dead, fires);
        check_eq("s4_ho_force_fires", 64'(fires),     64'd0);
        check_eq("s4_ntrig",          64'(NTRIGGERS), 64'd1);
        check_eq("s4_deadt",          64'(DEAD_TIME), 64'd21);
        settle();

        // 70 forced fires with no holdoff saturate all counters at 63.
        HOLDOFF = '0;
        for (int k = 0; k < 70; k++) begin
            FORCE_TRIGGER = 1'b1;
            tick();
            FORCE_TRIGGER = 1'b0;
            tick();
        end
        check_eq("sat_ntrig", 64'(NTRIGGERS), 64'd63);
        check_eq("sat_deadt", 64'(DEAD_TIME), 64'd63);
        check_eq("sat_livet", 64'(LIVE_TIME), 64'd63);
        FORCE_TRIGGER = 1'b1;
        tick();
        FORCE_TRIGGER = 1'b0;
        check_eq("clr_fire", 64'(TRIGGER_OUT), 64'd1);
        CLEAR_COUNTERS = 1'b1;
        tick();
        CLEAR_COUNTERS = 1'b0;
        check_eq("clr_beats_inc", 64'(NTRIGGERS), 64'd0);
        check_eq("clr_deadt",     64'(DEAD_TIME), 64'd0);
        settle();

        // Async reset during a long delay aborts the sequence.
        DELAY = 12'd100;
        FORCE_TRIGGER = 1'b1;
        tick();
        FORCE_TRIGGER = 1'b0;
        repeat (5) tick();
        check_eq("s6_in_delay", 64'(LIVE_ACQUISITION), 64'd0);
        RESET = 1'b0;
        ENABLE = 1'b0;
        ts_model = 0;
        #1;
        check_eq("s6_rst_trig",  64'(TRIGGER_OUT), 64'd0);
        check_eq("s6_rst_livet", 64'(LIVE_TIME),   64'd0);
        check_eq("s6_rst_ts",    64'(TIMESTAMP),   64'd0);
        repeat (2) tick();
        RESET = 1'b1;
        ENABLE = 1'b1;
        fires = 0;
        notlive = 0;
        repeat (120) begin
            tick();
            if (TRIGGER_OUT) fires++;
            if (!LIVE_ACQUISITION) notlive++;
        end
        check_eq("s6_no_fire",   64'(fires),   64'd0);
        check_eq("s6_all_idle",  64'(notlive), 64'd0);

        // Next fire after reset: timestamp captures the time base in the FIRE cycle.
        DELAY = 12'd2;
        FORCE_TRIGGER = 1'b1;
        tick();
        FORCE_TRIGGER = 1'b0;
        tick(); tick();
        check_eq("s6_fire", 64'(TRIGGER_OUT), 64'd1);
        exp_ts = ts_model;
        tick();
        check_eq("s6_ntrig", 64'(NTRIGGERS), 64'd1);
`ifdef TRIG_TIMESTAMP_EN
        check_eq("s6_ts", 64'(TIMESTAMP), exp_ts);
`else
        check_eq("s6_ts", 64'(TIMESTAMP), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/nch_trigger_sequencer.md
Name: nch_trigger_sequencer

Overview:
Parametrised N-channel successor to the fixed two-input trigger handler. It detects rising edges on N already-synchronised discriminator lines and opens a per-channel coincidence window on each edge. It forms a programmable majority coincidence under a channel mask, then runs a delay/fire/holdoff sequence. It also keeps saturating trigger, live-time and dead-time counters for readout over the I2C register map, and sits between the signal-input stage and the downstream event-stamping logic in the CLK_FAST domain.

Parameters:
N_CH, 4, number of input channels (2..8)
WIN_W, 8, coincidence window counter width
DLY_W, 12, delay counter width
HO_W, 16, holdoff counter width
CNT_W, 32, width of NTRIGGERS, LIVE_TIME, DEAD_TIME
TS_W, 48, timestamp width (optional feature only)

Ports:
CLK  in  1  fast clock
RESET  in  1  asynchronous, active-low reset
SIGNAL  in  N_CH  synchronised discriminator lines
CHANNEL_MASK  in  N_CH  1 = channel participates
MAJORITY  in  $clog2(N_CH+1)  required open-channel count; 0 disables coincidence triggering
WINDOW  in  WIN_W  window length in cycles; 0 treated as 1
DELAY  in  DLY_W  cycles from accept to fire
HOLDOFF  in  HO_W  dead cycles after fire
ENABLE  in  1  arm acquisition
FORCE_TRIGGER  in  1  software trigger, rising-edge detected
CLEAR_COUNTERS  in  1  synchronous clear of NTRIGGERS, LIVE_TIME, DEAD_TIME
TRIGGER_OUT  out  1  one-cycle fire strobe
LIVE_ACQUISITION  out  1  high while armed in IDLE
TRIGGER_PATTERN  out  N_CH  open-channel mask latched at accept
NTRIGGERS  out  CNT_W  fired-trigger count
LIVE_TIME  out  CNT_W  cycles with LIVE_ACQUISITION high
DEAD_TIME  out  CNT_W  cycles with ENABLE high and state not IDLE
TIMESTAMP  out  TS_W  free-running count latched at fire (optional feature)

Behaviour:
- Reset: state IDLE. All outputs, window counters, edge registers and counters go to 0.
- Edge detection: edge[i] = SIGNAL[i] & ~prev[i] & CHANNEL_MASK[i]. prev updates every cycle.
- Windows: on edge[i], win[i] loads max(WINDOW,1)-1. Otherwise it decrements while nonzero. Channel i is open when edge[i] is high or a prior window is still running. A re-edge inside a window reloads it.
- Coincidence: coinc = (MAJORITY != 0) & (popcount(open) >= MAJORITY). This is combinational on the sampling cycle.
- States:
  - IDLE: if ENABLE and (coinc or FORCE_TRIGGER edge), latch TRIGGER_PATTERN = open (all-zero for a pure force) and clear all windows. Go to FIRE if DELAY==0, else load DELAY-1 and go to DELAY.
  - DELAY: count down; at 0 go to FIRE.
  - FIRE: one cycle; TRIGGER_OUT=1; NTRIGGERS increments. Go to IDLE if HOLDOFF==0, else load HOLDOFF-1 and go to HOLDOFF.
  - HOLDOFF: count down; at 0 go to IDLE.
- Latency: the accept decision is made on clock k. With DELAY=0, TRIGGER_OUT is high in cycle k+1. With DELAY=D, it is high in cycle k+1+D.
- Outside IDLE: edges are ignored, windows are held at 0, and FORCE_TRIGGER is ignored. The previous-sample register still tracks SIGNAL, so a level held across holdoff does not retrigger.
- DELAY/HOLDOFF are sampled only at state entry. Mid-sequence config writes do not affect the running sequence.
- ENABLE deasserted mid-sequence: the sequence completes, then the block stays in IDLE with LIVE_ACQUISITION=0.
- Counters: saturate at all-ones, no wrap. CLEAR_COUNTERS has priority over increment in the same cycle.
- Async reset mid-sequence: immediate return to IDLE, no TRIGGER_OUT.

Optional Feature:
TRIG_TIMESTAMP_EN
- Defined: a TS_W-bit free-running counter runs from reset. TIMESTAMP latches the counter value in the FIRE cycle, visible the cycle after FIRE. TIMESTAMP is not cleared by CLEAR_COUNTERS.
- Undefined: no counter logic; TIMESTAMP is tied to 0.

Decomposition:
- Shared package trigger_pkg: state encoding (IDLE, DELAY, FIRE, HOLDOFF), default widths, saturating-increment helper function.
- One natural sub-module: coinc_window, a per-channel edge detector plus window counter instantiated N_CH times via generate.

Test Plan:
- N_CH=4, MASK=4'b1111, MAJORITY=2, WINDOW=5, DELAY=0, HOLDOFF=10; ch0 edge at cycle 0, ch2 edge at cycle 3 -> TRIGGER_OUT at cycle 4, PATTERN=4'b0101, NTRIGGERS=1, LIVE_ACQUISITION low for 11 cycles.
- Same config; ch0 edge at cycle 0, ch1 edge at cycle 6 -> no trigger; NTRIGGERS stays 0.
- MASK=4'b1110, MAJORITY=1; ch0 edge -> no trigger. Then ch3 edge with DELAY=3 -> TRIGGER_OUT exactly 4 cycles after the ch3 sample.
- MAJORITY=0, FORCE_TRIGGER pulse -> one fire with PATTERN=0. A second FORCE during HOLDOFF=20 is ignored.
- Counters at all-ones -> saturate; CLEAR_COUNTERS asserted together with FIRE -> NTRIGGERS=0 next cycle.
- RESET low during DELAY=100 -> state IDLE, no TRIGGER_OUT; with TRIG_TIMESTAMP_EN, TIMESTAMP=0 after reset and equals the counter value in the FIRE cycle on the next fire.
